commit_stage: RTL and testbench
===============================

# commit_stage

Final pipeline stage of the dual-issue core, directly downstream of the memory stage: it registers the two `CMT_REQUIRE` records the memory stage produces, retires them into the 32×32 architectural register file, and counts retired instructions. It also serves the four register read ports used by decode/issue, with write-through bypass from the commit register so a result is readable the cycle after the memory stage presents it.

## Interface
Parameters:
- `NREAD`, 4: number of register read ports (2 per issue slot).
- `CNT_W`, 64: width of the retired-instruction counter.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmt_require`  in  `CMT_REQUIRE[0:1]`  memory-stage output; fields `result` (32), `write_reg_need` (1), `write_reg_addr` (5). Slot 0 is older in program order.
- `cmt_valid`  in  2  per-slot valid for `cmt_require`.
- `stall`  in  1  hold: no capture, no retire this cycle.
- `rd_addr`  in  `NREAD`×5  register read addresses.
- `rd_data`  out  `NREAD`×32  combinational read data, bypassed.
- `wb_valid`  out  2  commit-register slot valid and `write_reg_need`, for hazard logic.
- `wb_addr`  out  2×5  commit-register destination per slot.
- `instret`  out  `CNT_W`  retired-instruction count.

## Operation
- Commit register (CR): per slot stores valid, `write_reg_need`, `write_reg_addr`, `result`.
- `stall` = 0: CR captures `cmt_require`/`cmt_valid`. The current CR contents retire on the same edge.
- `stall` = 1: CR holds. No array write. `instret` holds.
- Retire, on an edge with `stall` = 0: slot i writes `result` to `rf[write_reg_addr]` when valid_i, need_i, and addr_i ≠ 0.
- Same destination in both slots: slot 1's value lands (program order). Slot 0's write is suppressed.
- Register 0 is never written. Any read of address 0 returns 0, including via bypass.
- Read path, priority order for `rd_addr` = a ≠ 0:
  - CR slot 1 (valid, need, addr = a) → its result;
  - else CR slot 0 (same test) → its result;
  - else `rf[a]`.
- Bypass is active regardless of `stall`.
- `instret`: on retire, += number of valid CR slots. This counts instructions with and without register writes. Wraps modulo 2^`CNT_W`.
- `wb_valid[i]` = CR valid_i & need_i & (addr_i ≠ 0). `wb_addr[i]` = CR addr_i.

## Timing
- Reset (async assert, sync release) sets CR valid = 0, all `rf` entries = 0, `instret` = 0.
  - Outputs at reset: `wb_valid` = 0, `wb_addr` = 0, `rd_data` = 0 for every address.
  - CR contents pending at reset are discarded, never written.
- Latency:
  - Inputs presented in cycle N are captured at the end of N.
  - They are visible on `rd_data` via bypass throughout N+1.
  - They are written into `rf` at the end of N+1, if `stall` = 0 then.
  - `instret` reflects them from N+2.
- Stall held for k cycles: the CR value remains bypass-visible for all k cycles. It retires on the first edge with `stall` = 0.
- Inputs presented during stall are not captured. The upstream stage must hold them.
- No combinational path from `cmt_require` to `rd_data`. `rd_data` depends only on `rd_addr`, CR, and `rf`.

## Test plan
- Reset, then read all 32 addresses → all 0; `instret` = 0; `wb_valid` = 00.
- Cycle N: slot0 {valid, need, addr 5, 0xDEADBEEF}, slot1 invalid.
  - Cycle N+1: `rd_data` for addr 5 = 0xDEADBEEF (bypass), `wb_valid` = 01.
  - N+2: the value comes from `rf`; `instret` = 1.
- Both slots write addr 7: slot0 0x11111111, slot1 0x22222222.
  - N+1: read 7 = 0x22222222.
  - After retire: read 7 = 0x22222222; `instret` += 2.
- Slot0 write addr 0 with value 0xFFFFFFFF; slot1 valid with need = 0.
  - Read 0 = 0 always; `wb_valid` = 00; `instret` += 2.
- Capture addr 9 = 0xABCD, then `stall` = 1 for 3 cycles while new inputs change.
  - CR unchanged and read 9 = 0xABCD via bypass; `instret` frozen.
  - Release → retire, `rf[9]` = 0xABCD, new inputs captured.
- Preload `instret` near 2^`CNT_W`−1 (force, or `CNT_W` = 4 build), retire 2 → wraps to 0 then 1 as appropriate.
- Assert `rst_n` low mid-stall with CR valid → CR dropped, `rf` cleared, `instret` = 0.

Source files
------------

// File: rtl/commit_stage.sv
// commit_stage: registers two commit records, retires them into the 32x32
// register file, counts retired instructions, serves bypassed reads.
// Ports:
//   clk, rst_n   clock; asynchronous active-low reset
//   cmt_require  2 slots x 38b, slot i at [38*i +: 38] =
//                {result[31:0], write_reg_need, write_reg_addr[4:0]}
//   cmt_valid    per-slot valid for cmt_require
//   stall        hold: no capture, no retire
//   rd_addr      NREAD x 5b read addresses, port p at [5*p +: 5]
//   rd_data      NREAD x 32b bypassed read data, port p at [32*p +: 32]
//   wb_valid     commit-register slot valid and writing
//   wb_addr      commit-register destination, slot i at [5*i +: 5]
//   instret      retired-instruction count
module commit_stage #(
  parameter int NREAD = 4,
  parameter int CNT_W = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [75:0]        cmt_require,
  input  logic [1:0]         cmt_valid,
  input  logic               stall,
  input  logic [NREAD*5-1:0] rd_addr,
  output logic [NREAD*32-1:0] rd_data,
  output logic [1:0]         wb_valid,
  output logic [9:0]         wb_addr,
  output logic [CNT_W-1:0]   instret
);

  logic [1:0]       cr_valid;
  logic [1:0]       cr_need;
  logic [1:0][4:0]  cr_addr;
  logic [1:0][31:0] cr_result;
  logic [31:0]      rf [32];
  logic [1:0]       we;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      wb_valid[i]      = cr_valid[i] & cr_need[i]
                       & (cr_addr[i] != 5'd0);
      wb_addr[i*5 +: 5] = cr_addr[i];
    end
  end

  // Slot 1 is younger, so its write wins a same-register collision.
  always_comb begin
    we[1] = ~stall & wb_valid[1];
    we[0] = ~stall & wb_valid[0]
          & ~(wb_valid[1] & (cr_addr[1] == cr_addr[0]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_valid  <= '0;
      cr_need   <= '0;
      cr_addr   <= '0;
      cr_result <= '0;
    end else if (!stall) begin
      for (int i = 0; i < 2; i++) begin
        cr_valid[i]  <= cmt_valid[i];
        cr_addr[i]   <= cmt_require[38*i +: 5];
        cr_need[i]   <= cmt_require[38*i + 5];
        cr_result[i] <= cmt_require[38*i + 6 +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        rf[r] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (we[i]) begin
          rf[cr_addr[i]] <= cr_result[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (!stall) begin
      instret <= instret
               + CNT_W'(cr_valid[0])
               + CNT_W'(cr_valid[1]);
    end
  end

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NREAD; p++) begin
      if (rd_addr[p*5 +: 5] == 5'd0) begin
        rd_data[p*32 +: 32] = '0;
      end else if (wb_valid[1]
                   && cr_addr[1] == rd_addr[p*5 +: 5]) begin
        rd_data[p*32 +: 32] = cr_result[1];
      end else if (wb_valid[0]
                   && cr_addr[0] == rd_addr[p*5 +: 5]) begin
        rd_data[p*32 +: 32] = cr_result[0];
      end else begin
        rd_data[p*32 +: 32] = rf[rd_addr[p*5 +: 5]];
      end
    end
  end

endmodule

// File: tb/tb_commit_stage.sv
// tb_commit_stage: directed checks of commit_stage
// (4-bit retire counter build so wrap-around is reachable).
module tb_commit_stage;

  localparam int NREAD = 4;
  localparam int CNT_W = 4;

  logic               clk;
  logic               rst_n;
  logic [75:0]        cmt_require;
  logic [1:0]         cmt_valid;
  logic               stall;
  logic [NREAD*5-1:0] rd_addr;
  logic [NREAD*32-1:0] rd_data;
  logic [1:0]         wb_valid;
  logic [9:0]         wb_addr;
  logic [CNT_W-1:0]   instret;

  int n_cmp;
  int n_bad;

  commit_stage #(.NREAD(NREAD), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmt_require (cmt_require),
    .cmt_valid   (cmt_valid),
    .stall       (stall),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .instret     (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input int i, input logic need,
                      input logic [4:0] addr,
                      input logic [31:0] data);
    cmt_require[38*i +: 38] = {data, need, addr};
  endtask

  task automatic clr();
    cmt_require = '0;
    cmt_valid   = 2'b00;
  endtask

  task automatic rd_chk(input string tag, input int port,
                        input logic [4:0] addr,
                        input logic [31:0] exp);
    rd_addr[port*5 +: 5] = addr;
    #1;
    chk(tag, 64'(rd_data[port*32 +: 32]), 64'(exp));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    stall = 1'b0;
    rd_addr = '0;
    clr();
    step();
    step();
    rst_n = 1'b1;
    step();

    // reset state
    for (int a = 0; a < 32; a++) begin
      rd_chk("rst_rd", a % NREAD, 5'(a), 32'h0);
    end
    chk("rst_instret", 64'(instret), 64'd0);
    chk("rst_wbv", 64'(wb_valid), 64'd0);
    chk("rst_wba", 64'(wb_addr), 64'd0);

    // single write, bypass then rf
    slot(0, 1'b1, 5'd5, 32'hDEADBEEF);
    cmt_valid = 2'b01;
    step();
    clr();
    rd_chk("byp5", 0, 5'd5, 32'hDEADBEEF);
    chk("byp5_wbv", 64'(wb_valid), 64'b01);
    chk("byp5_wba", 64'(wb_addr[4:0]), 64'd5);
    chk("byp5_cnt", 64'(instret), 64'd0);
    step();
    rd_chk("rf5", 1, 5'd5, 32'hDEADBEEF);
    chk("rf5_wbv", 64'(wb_valid), 64'b00);
    chk("rf5_cnt", 64'(instret), 64'd1);

    // same destination in both slots
    slot(0, 1'b1, 5'd7, 32'h11111111);
    slot(1, 1'b1, 5'd7, 32'h22222222);
    cmt_valid = 2'b11;
    step();
    clr();
    rd_chk("byp7", 2, 5'd7, 32'h22222222);
    chk("byp7_wbv", 64'(wb_valid), 64'b11);
    step();
    rd_chk("rf7", 3, 5'd7, 32'h22222222);
    chk("rf7_cnt", 64'(instret), 64'd3);

    // write to x0 and a no-write instruction
    slot(0, 1'b1, 5'd0, 32'hFFFFFFFF);
    slot(1, 1'b0, 5'd3, 32'h00000033);
    cmt_valid = 2'b11;
    step();
    clr();
    rd_chk("x0_byp", 0, 5'd0, 32'h0);
    rd_chk("nn3_byp", 1, 5'd3, 32'h0);
    chk("x0_wbv", 64'(wb_valid), 64'b00);
    step();
    rd_chk("x0_rf", 0, 5'd0, 32'h0);
    rd_chk("nn3_rf", 1, 5'd3, 32'h0);
    chk("x0_cnt", 64'(instret), 64'd5);

    // stall hold for 3 cycles
    slot(0, 1'b1, 5'd9, 32'h0000ABCD);
    cmt_valid = 2'b01;
    step();
    stall = 1'b1;
    slot(0, 1'b1, 5'd10, 32'h55555555);
    for (int k = 0; k < 3; k++) begin
      rd_chk("stl_byp9", 3, 5'd9, 32'h0000ABCD);
      rd_chk("stl_10", 2, 5'd10, 32'h0);
      chk("stl_cnt", 64'(instret), 64'd5);
      chk("stl_wba", 64'(wb_addr[4:0]), 64'd9);
      step();
    end
    stall = 1'b0;
    step();
    clr();
    rd_chk("rel_rf9", 0, 5'd9, 32'h0000ABCD);
    rd_chk("rel_byp10", 1, 5'd10, 32'h55555555);
    chk("rel_cnt", 64'(instret), 64'd6);
    step();
    rd_chk("rel_rf10", 1, 5'd10, 32'h55555555);
    chk("rel_cnt2", 64'(instret), 64'd7);

    // counter wrap (4-bit): 7 + 8 = 15
    slot(0, 1'b0, 5'd1, 32'h1);
    slot(1, 1'b0, 5'd2, 32'h2);
    cmt_valid = 2'b11;
    for (int k = 0; k < 4; k++) step();
    clr();
    step();
    chk("wrap_15", 64'(instret), 64'd15);
    cmt_valid = 2'b01;
    step();
    clr();
    step();
    chk("wrap_0", 64'(instret), 64'd0);
    cmt_valid = 2'b11;
    step();
    clr();
    step();
    chk("wrap_2", 64'(instret), 64'd2);

    // reset during stall with a pending CR
    slot(0, 1'b1, 5'd12, 32'h00001234);
    cmt_valid = 2'b01;
    step();
    clr();
    step();
    rd_chk("pre_rf12", 0, 5'd12, 32'h00001234);
    slot(0, 1'b1, 5'd13, 32'h99999999);
    cmt_valid = 2'b01;
    step();
    clr();
    stall = 1'b1;
    step();
    rd_chk("pre_byp13", 1, 5'd13, 32'h99999999);
    chk("pre_wbv", 64'(wb_valid), 64'b01);
    rst_n = 1'b0;
    #1;
    chk("mrst_wbv", 64'(wb_valid), 64'b00);
    chk("mrst_cnt", 64'(instret), 64'd0);
    rd_chk("mrst_rf12", 0, 5'd12, 32'h0);
    rd_chk("mrst_13", 1, 5'd13, 32'h0);
    step();
    rst_n = 1'b1;
    stall = 1'b0;
    step();
    step();
    rd_chk("post_13", 1, 5'd13, 32'h0);
    rd_chk("post_12", 2, 5'd12, 32'h0);
    chk("post_cnt", 64'(instret), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
